// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the round-robin bus arbiter and its priority picker.
package bus_arbiter_rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Ceiling log2 with a floor of 1 bit, matching the bus mux select sizing.
    function automatic int log2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << width) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate, fixed-priority select, rotate back.
module rr_priority_pick
    import bus_arbiter_rr_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int SEL_W     = 2
) (
    input  logic [NUM_PORTS-1:0] request,
    input  logic [SEL_W-1:0]     last_owner,
    output logic [NUM_PORTS-1:0] winner_onehot,
    output logic [SEL_W-1:0]     winner_idx,
    output logic                 winner_valid
);

    localparam logic [SEL_W:0] PORTS_EXT = (SEL_W+1)'(NUM_PORTS);

    logic [SEL_W-1:0]     start_idx;
    logic [NUM_PORTS-1:0] rot_req;
    logic [SEL_W-1:0]     pick_pos;
    logic                 pick_valid;
    logic [SEL_W:0]       back_sum;

    // Scan begins one past the previous owner, wrapping at the top port.
    assign start_idx = (last_owner == SEL_W'(NUM_PORTS - 1)) ? '0 : last_owner + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
            logic [SEL_W:0]   fwd_sum;
            logic [SEL_W-1:0] fwd_idx;
            assign fwd_sum = {1'b0, start_idx} + (SEL_W+1)'(gi);
            assign fwd_idx = (fwd_sum >= PORTS_EXT) ? SEL_W'(fwd_sum - PORTS_EXT)
                                                    : SEL_W'(fwd_sum);
            assign rot_req[gi] = request[fwd_idx];
        end
    endgenerate

    always_comb begin
        pick_valid = 1'b0;
        pick_pos   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                pick_valid = 1'b1;
                pick_pos   = SEL_W'(i);
            end
        end
    end

    assign back_sum   = {1'b0, start_idx} + {1'b0, pick_pos};
    assign winner_idx = (back_sum >= PORTS_EXT) ? SEL_W'(back_sum - PORTS_EXT)
                                                : SEL_W'(back_sum);
    assign winner_valid = pick_valid;

    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_onehot
            assign winner_onehot[gi] = pick_valid && (winner_idx == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with multi-cycle hold and hold-limit preemption.
module bus_arbiter_rr
    import bus_arbiter_rr_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int MAX_HOLD  = 16,
    localparam int SEL_W     = log2(NUM_PORTS),
    localparam int HOLD_W    = log2(MAX_HOLD + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] request,
    output logic [NUM_PORTS-1:0] grant,
    output logic [SEL_W-1:0]     enable_port,
    output logic                 valid_enable,
    output logic [HOLD_W-1:0]    hold_count
);

    generate
        if (NUM_PORTS < 2) begin : g_param_check
            $fatal(1, "bus_arbiter_rr: NUM_PORTS must be at least 2");
        end
    endgenerate

    localparam bit              PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    // Without preemption the counter just saturates at its full range.
    localparam logic [HOLD_W-1:0] HOLD_SAT = PREEMPT_EN ? HOLD_MAX : '1;

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]     enable_q, enable_d;
    logic                 valid_q, valid_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [SEL_W-1:0]     last_owner_q, last_owner_d;

    logic [NUM_PORTS-1:0] pick_onehot;
    logic [SEL_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 owner_req;
    logic                 others_req;
    logic                 take_winner;

    rr_priority_pick #(
        .NUM_PORTS (NUM_PORTS),
        .SEL_W     (SEL_W)
    ) u_pick (
        .request       (request),
        .last_owner    (last_owner_q),
        .winner_onehot (pick_onehot),
        .winner_idx    (pick_idx),
        .winner_valid  (pick_valid)
    );

    assign owner_req  = |(request & grant_q);
    assign others_req = |(request & ~grant_q);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        enable_d     = enable_q;
        valid_d      = valid_q;
        hold_d       = hold_q;
        last_owner_d = last_owner_q;
        take_winner  = 1'b0;

        if (state_q == IDLE) begin
            take_winner = pick_valid;
        end else if (!owner_req) begin
            if (others_req) begin
                take_winner = 1'b1;
            end else begin
                state_d = IDLE;
                grant_d = '0;
                valid_d = 1'b0;
                hold_d  = '0;
            end
        end else if (PREEMPT_EN && (hold_q == HOLD_MAX) && others_req) begin
            // The owner sits last in the scan, so a waiting port always wins.
            take_winner = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
            hold_d = hold_q + 1'b1;
        end

        if (take_winner) begin
            state_d      = BUSY;
            grant_d      = pick_onehot;
            enable_d     = pick_idx;
            valid_d      = 1'b1;
            hold_d       = HOLD_W'(1);
            last_owner_d = pick_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            enable_q     <= '0;
            valid_q      <= 1'b0;
            hold_q       <= '0;
            last_owner_q <= SEL_W'(NUM_PORTS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            enable_q     <= enable_d;
            valid_q      <= valid_d;
            hold_q       <= hold_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign grant        = grant_q;
    assign enable_port  = enable_q;
    assign valid_enable = valid_q;
    assign hold_count   = hold_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed and random-stream checks for the round-robin bus arbiter.
module tb_bus_arbiter_rr;

    localparam int STARVE_BOUND = 3 * 16 + 4;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [3:0] grant;
    logic [1:0] enable_port;
    logic       valid_enable;
    logic [4:0] hold_count;

    logic [3:0] req4;
    logic [3:0] grant4;
    logic [1:0] enable4;
    logic       valid4;
    logic [2:0] hold4;

    int vecs = 0;
    int errs = 0;

    always #5 clock = ~clock;

    bus_arbiter_rr #(.NUM_PORTS(4), .MAX_HOLD(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .request      (request),
        .grant        (grant),
        .enable_port  (enable_port),
        .valid_enable (valid_enable),
        .hold_count   (hold_count)
    );

    bus_arbiter_rr #(.NUM_PORTS(4), .MAX_HOLD(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .request      (req4),
        .grant        (grant4),
        .enable_port  (enable4),
        .valid_enable (valid4),
        .hold_count   (hold4)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [31:0] g, input logic [31:0] en,
                            input logic [31:0] v, input logic [31:0] hc);
        chk({tag, "_grant"}, 32'(grant), g);
        chk({tag, "_enable"}, 32'(enable_port), en);
        chk({tag, "_valid"}, 32'(valid_enable), v);
        chk({tag, "_hold"}, 32'(hold_count), hc);
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    initial begin
        int         wait_cnt [4];
        logic [3:0] rq;

        // Reset with all ports requesting, then full preemption rotation.
        reset   = 1'b1;
        request = 4'b1111;
        req4    = 4'b0000;
        tick();
        tick();
        chk_main("rst", 32'h0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int h = 1; h <= 16; h++) begin
                chk("t1_grant", 32'(grant), 32'(1 << (k % 4)));
                chk("t1_enable", 32'(enable_port), 32'(k % 4));
                chk("t1_hold", 32'(hold_count), 32'(h));
                tick();
            end
        end
        chk_main("t1_next", 32'h2, 32'h1, 32'h1, 32'h1);
        request = 4'b0000;
        tick();
        chk_main("t1_idle", 32'h0, 32'h1, 32'h0, 32'h0);

        // Single port pulse from idle.
        request = 4'b0100;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk_main("t2_pulse", 32'h4, 32'h2, 32'h1, 32'(i));
        end
        request = 4'b0000;
        tick();
        chk_main("t2_release", 32'h0, 32'h2, 32'h0, 32'h0);

        // Port 3 hands over to port 0 by wrap-around, no bubble.
        request = 4'b1000;
        tick();
        chk_main("t3_own3", 32'h8, 32'h3, 32'h1, 32'h1);
        request = 4'b1101;
        tick();
        chk_main("t3_keep3", 32'h8, 32'h3, 32'h1, 32'h2);
        request = 4'b0101;
        tick();
        chk_main("t3_wrap0", 32'h1, 32'h0, 32'h1, 32'h1);
        request = 4'b0100;
        tick();
        chk_main("t3_to2", 32'h4, 32'h2, 32'h1, 32'h1);
        request = 4'b0000;
        tick();
        chk_main("t3_idle", 32'h0, 32'h2, 32'h0, 32'h0);

        // MAX_HOLD=4 instance: preemption after exactly four cycles, then saturation.
        req4 = 4'b0010;
        tick();
        chk("t4_g1", 32'(grant4), 32'h2);
        chk("t4_h1", 32'(hold4), 32'h1);
        req4 = 4'b0110;
        for (int h = 2; h <= 4; h++) begin
            tick();
            chk("t4_hold_g", 32'(grant4), 32'h2);
            chk("t4_hold_h", 32'(hold4), 32'(h));
        end
        tick();
        chk("t4_preempt_g", 32'(grant4), 32'h4);
        chk("t4_preempt_en", 32'(enable4), 32'h2);
        chk("t4_preempt_h", 32'(hold4), 32'h1);
        req4 = 4'b0010;
        tick();
        chk("t4_back_g", 32'(grant4), 32'h2);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t4_sat_g", 32'(grant4), 32'h2);
            chk("t4_sat_h", 32'(hold4), (i < 3) ? 32'(i + 2) : 32'h4);
        end
        req4 = 4'b0000;
        tick();
        chk("t4_idle_v", 32'(valid4), 32'h0);

        // Reset mid-transaction; first winner comes from last_owner=3.
        request = 4'b0100;
        tick();
        chk_main("t5_own2", 32'h4, 32'h2, 32'h1, 32'h1);
        tick();
        chk_main("t5_mid", 32'h4, 32'h2, 32'h1, 32'h2);
        reset   = 1'b1;
        request = 4'b1100;
        tick();
        chk_main("t5_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
        chk_main("t5_first", 32'h4, 32'h2, 32'h1, 32'h1);

        // Random request streams with structural and fairness checks.
        reset   = 1'b1;
        request = 4'b0000;
        tick();
        reset = 1'b0;
        rq    = 4'b0000;
        for (int p = 0; p < 4; p++) wait_cnt[p] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                if (rq[p]) begin
                    if (grant[p] && ($urandom_range(5) == 0)) rq[p] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    rq[p] = 1'b1;
                end
            end
            request = rq;
            tick();
            chk("r_onehot", 32'($countones(grant) <= 1), 32'h1);
            chk("r_valid", 32'(valid_enable), 32'(|grant));
            if (valid_enable) chk("r_enable", 32'(enable_port), 32'(idx_of(grant)));
            chk("r_hold_max", 32'(hold_count <= 5'd16), 32'h1);
            for (int p = 0; p < 4; p++) begin
                if (request[p] && !grant[p]) wait_cnt[p]++;
                else wait_cnt[p] = 0;
                chk("r_starve", 32'(wait_cnt[p] <= STARVE_BOUND), 32'h1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
